// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the three-port SRAM request arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int PORT_VID     = 0;
  localparam int PORT_CPU     = 1;
  localparam int PORT_DMA     = 2;
  localparam int GUARD_CYCLES = 2;

endpackage

// File: rtl/sram_arbiter_if.sv
// Client ports (video, cpu, dma) and RAM controller strobe bus of the arbiter.
interface sram_arbiter_if;

  logic        p0_req;
  logic        p0_we;
  logic [24:0] p0_addr;
  logic [15:0] p0_dout;
  logic        p0_ack;

  logic        p1_req;
  logic        p1_we;
  logic [24:0] p1_addr;
  logic [15:0] p1_din;
  logic [1:0]  p1_wtbt;
  logic [15:0] p1_dout;
  logic        p1_ack;

  logic        p2_req;
  logic        p2_we;
  logic [24:0] p2_addr;
  logic [15:0] p2_din;
  logic [1:0]  p2_wtbt;
  logic [15:0] p2_dout;
  logic        p2_ack;

  logic [24:0] m_addr;
  logic [15:0] m_din;
  logic [1:0]  m_wtbt;
  logic        m_we;
  logic        m_rd;
  logic [15:0] m_dout;
  logic        m_ready;

  modport master (
    input  p0_req, p0_we, p0_addr,
    input  p1_req, p1_we, p1_addr, p1_din, p1_wtbt,
    input  p2_req, p2_we, p2_addr, p2_din, p2_wtbt,
    input  m_dout, m_ready,
    output p0_dout, p0_ack, p1_dout, p1_ack, p2_dout, p2_ack,
    output m_addr, m_din, m_wtbt, m_we, m_rd
  );

  modport slave (
    output p0_req, p0_we, p0_addr,
    output p1_req, p1_we, p1_addr, p1_din, p1_wtbt,
    output p2_req, p2_we, p2_addr, p2_din, p2_wtbt,
    output m_dout, m_ready,
    input  p0_dout, p0_ack, p1_dout, p1_ack, p2_dout, p2_ack,
    input  m_addr, m_din, m_wtbt, m_we, m_rd
  );

endinterface

// File: rtl/sram_arb_pick.sv
// Combinational picker: video has absolute priority, cpu/dma share by pointer.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic       ptr_dma,
  output logic [2:0] grant,
  output logic       valid
);

  always_comb begin
    grant = '0;
    if (req[PORT_VID])
      grant[PORT_VID] = 1'b1;
    else if (req[PORT_CPU] && (!ptr_dma || !req[PORT_DMA]))
      grant[PORT_CPU] = 1'b1;
    else if (req[PORT_DMA])
      grant[PORT_DMA] = 1'b1;
  end

  assign valid = |req;

endmodule

// File: rtl/sram_arbiter.sv
// Serialises three level-held requests onto the RAM controller rd/we strobes.
// state | meaning: IDLE wait ready+req | GUARD ignore stale ready | WAIT for ready | DONE strobe low, ack
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter logic [7:0]  WD_CYCLES  = 8'd200,
  parameter logic [15:0] ABORT_DATA = 16'hFFFF
) (
  input  logic           clk,
  input  logic           reset_n,
  sram_arbiter_if.master bus,
  output logic           wd_err
);

  arb_state_t  state;
  logic [2:0]  req, grant, own, ack;
  logic        valid, ptr_dma, wd_hit, fin, fin_abort;
  logic [1:0]  guard_cnt;
  logic [7:0]  wd_cnt;
  logic [24:0] addr_q;
  logic [15:0] din_q, rdata, dout0, dout1, dout2;
  logic [1:0]  wtbt_q;
  logic        we_q, rd_q;

  assign req = {bus.p2_req, bus.p1_req, bus.p0_req};

  sram_arb_pick u_pick (
    .req     (req),
    .ptr_dma (ptr_dma),
    .grant   (grant),
    .valid   (valid)
  );

  // Normal completion takes precedence over a watchdog expiry in the same cycle.
  always_comb begin
    wd_hit    = (wd_cnt == WD_CYCLES - 8'd1);
    fin       = 1'b0;
    fin_abort = 1'b0;
    if (state == WAIT && bus.m_ready) begin
      fin = 1'b1;
    end else if ((state == GUARD || state == WAIT) && wd_hit) begin
      fin       = 1'b1;
      fin_abort = 1'b1;
    end
    rdata = fin_abort ? ABORT_DATA : bus.m_dout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      own       <= '0;
      ack       <= '0;
      ptr_dma   <= 1'b0;
      guard_cnt <= '0;
      wd_cnt    <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      wtbt_q    <= 2'b00;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      dout0     <= '0;
      dout1     <= '0;
      dout2     <= '0;
      wd_err    <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (bus.m_ready && valid) begin
            state     <= GUARD;
            own       <= grant;
            wd_cnt    <= '0;
            guard_cnt <= 2'(GUARD_CYCLES - 1);
            // Video is read-only: its we bit is deliberately not looked at.
            if (grant[PORT_VID]) begin
              addr_q <= bus.p0_addr;
              din_q  <= '0;
              wtbt_q <= 2'b00;
              we_q   <= 1'b0;
              rd_q   <= 1'b1;
            end else if (grant[PORT_CPU]) begin
              addr_q  <= bus.p1_addr;
              din_q   <= bus.p1_din;
              wtbt_q  <= bus.p1_wtbt;
              we_q    <= bus.p1_we;
              rd_q    <= !bus.p1_we;
              ptr_dma <= 1'b1;
            end else begin
              addr_q  <= bus.p2_addr;
              din_q   <= bus.p2_din;
              wtbt_q  <= bus.p2_wtbt;
              we_q    <= bus.p2_we;
              rd_q    <= !bus.p2_we;
              ptr_dma <= 1'b0;
            end
          end
        end
        GUARD, WAIT: begin
          wd_cnt <= wd_cnt + 8'd1;
          if (fin) begin
            state <= DONE;
            we_q  <= 1'b0;
            rd_q  <= 1'b0;
            ack   <= own;
            if (!we_q) begin
              if (own[PORT_VID]) dout0 <= rdata;
              if (own[PORT_CPU]) dout1 <= rdata;
              if (own[PORT_DMA]) dout2 <= rdata;
            end
            if (fin_abort) wd_err <= 1'b1;
          end else if (state == GUARD) begin
            if (guard_cnt == '0) state <= WAIT;
            else guard_cnt <= guard_cnt - 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_addr  = addr_q;
  assign bus.m_din   = din_q;
  assign bus.m_wtbt  = wtbt_q;
  assign bus.m_we    = we_q;
  assign bus.m_rd    = rd_q;
  assign bus.p0_ack  = ack[PORT_VID];
  assign bus.p1_ack  = ack[PORT_CPU];
  assign bus.p2_ack  = ack[PORT_DMA];
  assign bus.p0_dout = dout0;
  assign bus.p1_dout = dout1;
  assign bus.p2_dout = dout2;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: controller model plus an ack scoreboard for sram_arbiter.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam logic [7:0]  WD    = 8'd200;
  localparam logic [15:0] ABORT = 16'hFFFF;
  localparam int M_NORM = 0, M_HIT = 1, M_DEAD = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wd_err;

  always #5 clk = ~clk;

  sram_arbiter_if bus();

  sram_arbiter #(.WD_CYCLES(WD), .ABORT_DATA(ABORT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .wd_err  (wd_err)
  );

  typedef struct {
    int          port;
    logic        rd;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   rem[3] = '{0, 0, 0};
  int   acks[3] = '{0, 0, 0};
  logic ack_seen;
  int   mode = M_NORM, lat = 6, mcnt = 0;
  logic busy = 1'b0, prev = 1'b0;

  function automatic logic [15:0] rd_fn(logic [24:0] a);
    return a[15:0] ^ 16'hA45A;
  endfunction

  // Controller model: ready drops on each strobe rising edge, returns after lat cycles.
  always @(negedge clk) begin
    if (!reset_n) begin
      bus.m_ready = 1'b1;
      bus.m_dout  = '0;
      busy = 1'b0;
      prev = 1'b0;
      mcnt = 0;
    end else begin
      if ((bus.m_rd || bus.m_we) && !prev) begin
        if (mode == M_HIT) begin
          bus.m_ready = 1'b1;
          bus.m_dout  = rd_fn(bus.m_addr);
        end else begin
          bus.m_ready = 1'b0;
          busy = 1'b1;
          mcnt = lat;
        end
      end else if (busy && mode != M_DEAD) begin
        if (mcnt <= 1) begin
          bus.m_ready = 1'b1;
          bus.m_dout  = rd_fn(bus.m_addr);
          busy = 1'b0;
        end else begin
          mcnt--;
        end
      end
      prev = bus.m_rd || bus.m_we;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(int p);
    case (p)
      0:       return bus.p0_ack;
      1:       return bus.p1_ack;
      default: return bus.p2_ack;
    endcase
  endfunction

  function automatic logic [15:0] dout_of(int p);
    case (p)
      0:       return bus.p0_dout;
      1:       return bus.p1_dout;
      default: return bus.p2_dout;
    endcase
  endfunction

  task automatic set_req(int p, logic v);
    case (p)
      0:       bus.p0_req = v;
      1:       bus.p1_req = v;
      default: bus.p2_req = v;
    endcase
  endtask

  task automatic push(int p, logic rd, logic [15:0] d);
    exp_t e;
    e.port = p;
    e.rd   = rd;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic issue(int p, int n, logic we, logic [24:0] a, logic [15:0] d, logic [1:0] w);
    case (p)
      0: begin bus.p0_we = we; bus.p0_addr = a; end
      1: begin bus.p1_we = we; bus.p1_addr = a; bus.p1_din = d; bus.p1_wtbt = w; end
      default: begin bus.p2_we = we; bus.p2_addr = a; bus.p2_din = d; bus.p2_wtbt = w; end
    endcase
    rem[p] = n;
    set_req(p, 1'b1);
  endtask

  // One clock; any ack seen is checked against the scoreboard and retires a request.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    ack_seen = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (ack_of(p)) begin
        ack_seen = 1'b1;
        acks[p]++;
        chk("strobe_low_at_ack", {30'd0, bus.m_rd, bus.m_we}, 32'd0);
        chk("pending_at_ack", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("ack_port", p, e.port);
          if (e.rd) chk("read_data", dout_of(p), e.data);
        end
        if (rem[p] > 0) rem[p]--;
        if (rem[p] == 0) set_req(p, 1'b0);
      end
    end
  endtask

  task automatic drain(int budget);
    int c = 0;
    while ((sb.size() != 0 || rem[0] != 0 || rem[1] != 0 || rem[2] != 0) && c < budget) begin
      step();
      c++;
    end
    chk("drain_done", (sb.size() == 0 && rem[0] == 0 && rem[1] == 0 && rem[2] == 0), 1);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_din = '0; bus.p1_wtbt = '0;
    bus.p2_req = 0; bus.p2_we = 0; bus.p2_addr = '0; bus.p2_din = '0; bus.p2_wtbt = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_rd", bus.m_rd, 0);
    chk("rst_m_we", bus.m_we, 0);
    chk("rst_wd_err", wd_err, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_din", bus.m_din, 0);
    chk("rst_m_wtbt", bus.m_wtbt, 0);
    chk("rst_acks", {bus.p2_ack, bus.p1_ack, bus.p0_ack}, 0);
    chk("rst_p0_dout", bus.p0_dout, 0);
    chk("rst_p1_dout", bus.p1_dout, 0);
    chk("rst_p2_dout", bus.p2_dout, 0);
    #2 reset_n = 1'b1;
    step();
    step();

    // Single cpu read
    issue(1, 1, 1'b0, 25'h000100, 16'h0, 2'b00);
    push(1, 1'b1, 16'hA55A);
    step();
    chk("t1_rd_at_grant", bus.m_rd, 1);
    chk("t1_we_at_grant", bus.m_we, 0);
    chk("t1_addr", bus.m_addr, 32'h100);
    drain(100);
    chk("t1_ack_once", acks[1], 1);

    // cpu write
    issue(1, 1, 1'b1, 25'h000200, 16'h1234, 2'b01);
    push(1, 1'b0, 16'h0);
    step();
    chk("t2_we_at_grant", bus.m_we, 1);
    chk("t2_rd_at_grant", bus.m_rd, 0);
    chk("t2_din", bus.m_din, 32'h1234);
    chk("t2_wtbt", bus.m_wtbt, 32'h1);
    drain(100);
    chk("t2_p1_dout_kept", bus.p1_dout, 32'hA55A);

    // dma read (leaves the pointer preferring cpu)
    issue(2, 1, 1'b0, 25'h0002AA, 16'h0, 2'b00);
    push(2, 1'b1, rd_fn(25'h0002AA));
    step();
    chk("t2b_rd_at_grant", bus.m_rd, 1);
    chk("t2b_addr", bus.m_addr, 32'h2AA);
    drain(100);

    // cpu/dma alternation with a video (write-flagged) request arriving mid-stream
    push(1, 1'b1, rd_fn(25'h111));
    push(2, 1'b1, rd_fn(25'h222));
    push(0, 1'b1, rd_fn(25'h333));
    for (int i = 0; i < 3; i++) begin
      push(1, 1'b1, rd_fn(25'h111));
      push(2, 1'b1, rd_fn(25'h222));
    end
    issue(1, 4, 1'b0, 25'h000111, 16'h0, 2'b00);
    issue(2, 4, 1'b0, 25'h000222, 16'h0, 2'b00);
    e = 0;
    do begin
      step();
      e++;
    end while (!(ack_seen && bus.p2_ack) && e < 200);
    chk("t3_first_dma_ack", bus.p2_ack, 1);
    issue(0, 1, 1'b1, 25'h000333, 16'h0, 2'b00);
    drain(600);
    chk("t3_vid_acks", acks[0], 1);

    // Read-hit: ready held high, completion after the guard
    mode = M_HIT;
    issue(1, 1, 1'b0, 25'h000345, 16'h0, 2'b00);
    push(1, 1'b1, rd_fn(25'h345));
    step();
    chk("t4_rd_at_grant", bus.m_rd, 1);
    e = 0;
    do begin
      step();
      e++;
    end while (!ack_seen && e < 20);
    chk("t4_hit_edges_to_ack", e, 3);
    mode = M_NORM;
    step();

    // Watchdog: controller never answers
    mode = M_DEAD;
    issue(1, 1, 1'b0, 25'h000400, 16'h0, 2'b00);
    push(1, 1'b1, ABORT);
    step();
    chk("t5_rd_at_grant", bus.m_rd, 1);
    chk("t5_wd_err_before", wd_err, 0);
    e = 0;
    do begin
      step();
      e++;
    end while (!ack_seen && e < 400);
    chk("t5_wd_edges_to_ack", e, WD);
    chk("t5_wd_err_set", wd_err, 1);
    mode = M_NORM;
    issue(1, 1, 1'b0, 25'h000404, 16'h0, 2'b00);
    push(1, 1'b1, rd_fn(25'h404));
    drain(100);
    chk("t5_wd_err_sticky", wd_err, 1);

    // Reset in WAIT: everything clears at once, no ack
    lat = 20;
    issue(2, 1, 1'b0, 25'h000500, 16'h0, 2'b00);
    push(2, 1'b1, rd_fn(25'h500));
    step();
    chk("t6_rd_at_grant", bus.m_rd, 1);
    repeat (5) step();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_m_rd_cleared", bus.m_rd, 0);
    chk("t6_m_addr_cleared", bus.m_addr, 0);
    chk("t6_wd_err_cleared", wd_err, 0);
    chk("t6_p1_dout_cleared", bus.p1_dout, 0);
    chk("t6_p2_dout_cleared", bus.p2_dout, 0);
    chk("t6_no_ack", bus.p2_ack, 0);
    sb.delete();
    for (int p = 0; p < 3; p++) begin
      rem[p] = 0;
      set_req(p, 1'b0);
    end
    step();
    step();
    lat = 6;
    reset_n = 1'b1;
    step();
    issue(1, 1, 1'b0, 25'h000600, 16'h0, 2'b00);
    push(1, 1'b1, rd_fn(25'h600));
    step();
    chk("t6_rd_after_release", bus.m_rd, 1);
    drain(100);
    chk("t6_wd_err_after", wd_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
